display_monitor: RTL and testbench

Receive-side companion to the display pattern generators: consumes the registered `disp_*` output bus of a generator and recovers the display timing (active width, active height, line period, frame period, sync polarity) plus a per-frame pixel signature. It sits on the sink side of the display bus, in simulation benches and on-chip self-check. Each frame's results are published with a one-cycle valid strobe. A lock FSM reports when timing has been stable for consecutive frames.

---
 rtl/display_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_display_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/display_monitor.sv
// display_monitor: recovers display timing and a per-frame pixel signature from a disp_* bus.
// Latency: results and lock status appear one cycle after the closing disp_frame.
// Backpressure: none; the monitor observes every cycle and never stalls the source.
module display_monitor #(
  parameter int BPC         = 5,
  parameter int CORDW       = 16,
  parameter int CNTW        = 24,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_hsync,
  input  logic             disp_vsync,
  input  logic             disp_de,
  input  logic             disp_frame,
  input  logic [BPC-1:0]   disp_r,
  input  logic [BPC-1:0]   disp_g,
  input  logic [BPC-1:0]   disp_b,
  output logic [CORDW-1:0] hres,
  output logic [CORDW-1:0] vres,
  output logic [CORDW-1:0] htotal,
  output logic [CNTW-1:0]  frame_cycles,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic [31:0]      sig,
  output logic             frame_err,
  output logic             stat_valid,
  output logic             locked
);

  localparam int                LCW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCW-1:0]    LOCK_N   = LCW'(LOCK_FRAMES);
  localparam logic [CORDW-1:0]  CORD_MAX = '1;
  localparam logic [CNTW-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Accumulators for the frame window currently being observed
  logic [CNTW-1:0]  r_fcnt;
  logic             r_prev_de;
  logic [CORDW-1:0] r_nruns;
  logic [CORDW-1:0] r_run_len;
  logic [CORDW-1:0] r_hres_acc;
  logic             r_hres_set;
  logic [CORDW-1:0] r_htot_acc;
  logic [CORDW-1:0] r_since;
  logic             r_err_acc;
  logic [31:0]      r_sig_acc;
  logic             r_hs_acc;
  logic             r_vs_acc;

  // Published results and lock bookkeeping
  logic [CORDW-1:0] r_hres;
  logic [CORDW-1:0] r_vres;
  logic [CORDW-1:0] r_htotal;
  logic [CNTW-1:0]  r_frame_cycles;
  logic             r_hs_pol;
  logic             r_vs_pol;
  logic [31:0]      r_sig;
  logic             r_frame_err;
  logic             r_stat_valid;
  logic             r_locked;
  logic             r_have_prev;
  logic [LCW-1:0]   r_cnt;

  logic [31:0]      w_pix;
  logic             w_rise;
  logic             w_fall;
  logic             w_close;
  logic             w_err_evt;
  logic             w_ivl_use;
  logic [CORDW-1:0] w_fin_hres;
  logic             w_fin_err;
  logic             w_match;
  logic [LCW-1:0]   w_cnt_nxt;

  assign w_pix   = 32'({disp_r, disp_g, disp_b});
  // A DE cycle on the boundary opens a new run in the new window regardless of history
  assign w_rise  = disp_de & (~r_prev_de | disp_frame);
  // Falling edges on the boundary cycle are handled by the close logic instead
  assign w_fall  = r_prev_de & ~disp_de & ~disp_frame;
  assign w_close = disp_frame & (r_state != S_IDLE);

  // In-window error events and the closing-frame view of the accumulators
  always_comb begin
    w_ivl_use  = w_rise & (r_nruns != '0);
    w_err_evt  = (r_fcnt == CNT_MAX)
               | (disp_de & ~w_rise & (r_run_len == CORD_MAX))
               | (w_rise & (r_nruns == CORD_MAX))
               | (w_fall & r_hres_set & (r_run_len != r_hres_acc))
               | (w_ivl_use & (r_since == CORD_MAX))
               | (w_ivl_use & (r_nruns >= CORDW'(2)) & (r_since != r_htot_acc));
    // A run still open at the boundary ends there
    w_fin_hres = (!r_hres_set && r_prev_de) ? r_run_len : r_hres_acc;
    w_fin_err  = r_err_acc | (r_nruns == '0)
               | (r_hres_set & r_prev_de & (r_run_len != r_hres_acc));
    w_match    = r_have_prev & ~w_fin_err
               & (w_fin_hres == r_hres) & (r_nruns == r_vres)
               & (r_htot_acc == r_htotal) & (r_fcnt == r_frame_cycles);
    if (!w_match)           w_cnt_nxt = '0;
    else if (r_cnt == LOCK_N) w_cnt_nxt = r_cnt;
    else                    w_cnt_nxt = r_cnt + 1'b1;
  end

  // Per-cycle accumulation; disp_frame restarts the window including its own cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt     <= '0;
      r_prev_de  <= 1'b0;
      r_nruns    <= '0;
      r_run_len  <= '0;
      r_hres_acc <= '0;
      r_hres_set <= 1'b0;
      r_htot_acc <= '0;
      r_since    <= '0;
      r_err_acc  <= 1'b0;
      r_sig_acc  <= '0;
      r_hs_acc   <= 1'b0;
      r_vs_acc   <= 1'b0;
    end else if (disp_frame) begin
      r_fcnt     <= CNTW'(1);
      r_prev_de  <= disp_de;
      r_nruns    <= disp_de ? CORDW'(1) : '0;
      r_run_len  <= disp_de ? CORDW'(1) : '0;
      r_hres_acc <= '0;
      r_hres_set <= 1'b0;
      r_htot_acc <= '0;
      r_since    <= CORDW'(1);
      r_err_acc  <= disp_de;
      r_sig_acc  <= disp_de ? w_pix : '0;
      r_hs_acc   <= disp_de & ~disp_hsync;
      r_vs_acc   <= disp_de & ~disp_vsync;
    end else begin
      r_prev_de <= disp_de;
      r_err_acc <= r_err_acc | w_err_evt;
      if (r_fcnt != CNT_MAX) r_fcnt <= r_fcnt + 1'b1;
      if (w_rise) begin
        r_since   <= CORDW'(1);
        r_run_len <= CORDW'(1);
        if (r_nruns != CORD_MAX) r_nruns <= r_nruns + 1'b1;
        if (w_ivl_use && r_nruns == CORDW'(1)) r_htot_acc <= r_since;
      end else begin
        if (r_since != CORD_MAX) r_since <= r_since + 1'b1;
        if (disp_de && r_run_len != CORD_MAX) r_run_len <= r_run_len + 1'b1;
      end
      if (w_fall && !r_hres_set) begin
        r_hres_acc <= r_run_len;
        r_hres_set <= 1'b1;
      end
      if (disp_de) begin
        r_sig_acc <= {r_sig_acc[30:0], r_sig_acc[31]} ^ w_pix;
        r_hs_acc  <= ~disp_hsync;
        r_vs_acc  <= ~disp_vsync;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Lock FSM next-state: leave IDLE on first frame, lock on enough matches, drop on any miss
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (disp_frame) w_state_nxt = S_MEASURE;
      S_MEASURE: if (disp_frame && w_cnt_nxt == LOCK_N) w_state_nxt = S_LOCKED;
      S_LOCKED:  if (disp_frame && !w_match) w_state_nxt = S_MEASURE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Publish closed-frame results and lock status with a one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hres         <= '0;
      r_vres         <= '0;
      r_htotal       <= '0;
      r_frame_cycles <= '0;
      r_hs_pol       <= 1'b0;
      r_vs_pol       <= 1'b0;
      r_sig          <= '0;
      r_frame_err    <= 1'b0;
      r_stat_valid   <= 1'b0;
      r_locked       <= 1'b0;
      r_have_prev    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_stat_valid <= w_close;
      if (w_close) begin
        r_hres         <= w_fin_hres;
        r_vres         <= r_nruns;
        r_htotal       <= r_htot_acc;
        r_frame_cycles <= r_fcnt;
        r_hs_pol       <= r_hs_acc;
        r_vs_pol       <= r_vs_acc;
        r_sig          <= r_sig_acc;
        r_frame_err    <= w_fin_err;
        r_have_prev    <= 1'b1;
        r_cnt          <= w_cnt_nxt;
        r_locked       <= (w_cnt_nxt == LOCK_N);
      end
    end
  end

  assign hres         = r_hres;
  assign vres         = r_vres;
  assign htotal       = r_htotal;
  assign frame_cycles = r_frame_cycles;
  assign hs_pol       = r_hs_pol;
  assign vs_pol       = r_vs_pol;
  assign sig          = r_sig;
  assign frame_err    = r_frame_err;
  assign stat_valid   = r_stat_valid;
  assign locked       = r_locked;

endmodule

// File: tb/tb_display_monitor.sv
// Testbench for display_monitor: directed frames with hand-computed timing results.
// Inputs are driven and outputs observed on the falling clock edge.
// Every result strobe is recorded with its cycle number and checked afterwards.
module tb_display_monitor;

  localparam int BPC   = 5;
  localparam int CORDW = 16;
  localparam int CNTW  = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             disp_hsync = 1'b0, disp_vsync = 1'b0, disp_de = 1'b0, disp_frame = 1'b0;
  logic [BPC-1:0]   disp_r = '0, disp_g = '0, disp_b = '0;
  logic [CORDW-1:0] hres, vres, htotal;
  logic [CNTW-1:0]  frame_cycles;
  logic             hs_pol, vs_pol, frame_err, stat_valid, locked;
  logic [31:0]      sig;

  always #5 clk = ~clk;

  display_monitor #(.BPC(BPC), .CORDW(CORDW), .CNTW(CNTW), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de), .disp_frame(disp_frame),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .hres(hres), .vres(vres), .htotal(htotal), .frame_cycles(frame_cycles),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .sig(sig), .frame_err(frame_err),
    .stat_valid(stat_valid), .locked(locked)
  );

  typedef struct {
    int               cyc;
    logic [CORDW-1:0] hres, vres, htotal;
    logic [CNTW-1:0]  fc;
    logic             hp, vp, err, lk;
    logic [31:0]      sig;
  } res_t;

  res_t         sq[$];
  int           fq[$];
  int           ncyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [108:0] obs_all;
  logic [108:0] rst_snap = '1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic res_t sget(input int i);
    res_t z;
    z = '{default: '0};
    z.cyc = -1000;
    if (i < sq.size()) z = sq[i];
    return z;
  endfunction

  function automatic int fget(input int i);
    return (i < fq.size()) ? fq[i] : -1000;
  endfunction

  // One clock: observe outputs settled from the previous edge, then drive this cycle
  task automatic cycle(input logic f, input logic de, input logic hs, input logic vs,
                       input logic [BPC-1:0] r, input logic [BPC-1:0] g,
                       input logic [BPC-1:0] b, input logic rs);
    res_t s;
    @(negedge clk);
    ncyc++;
    obs_all = {hres, vres, htotal, frame_cycles, hs_pol, vs_pol, sig, frame_err, stat_valid, locked};
    if (stat_valid) begin
      s.cyc = ncyc; s.hres = hres; s.vres = vres; s.htotal = htotal; s.fc = frame_cycles;
      s.hp = hs_pol; s.vp = vs_pol; s.err = frame_err; s.lk = locked; s.sig = sig;
      sq.push_back(s);
    end
    rst = rs; disp_frame = f; disp_de = de; disp_hsync = hs; disp_vsync = vs;
    disp_r = r; disp_g = g; disp_b = b;
    if (f && !rs) fq.push_back(ncyc);
  endtask

  // mode 0: 20-cycle lines, DE at x=4..15 on lines 0..7 (line shl has 11), 10 lines
  // mode 1: DE on c=3 (r=1) and c=4 (b=1) only
  // mode 2: one DE run of 65536 cycles starting at c=4
  task automatic run_frame(input int mode, input int ftot, input int shl,
                           input bit hs_hi, input bit vs_hi, input int rst_at);
    for (int c = 0; c < ftot; c++) begin
      int line, x, len;
      logic de, hs, vs;
      logic [BPC-1:0] r, b;
      line = c / 20; x = c % 20;
      len = (line == shl) ? 11 : 12;
      r = '0; b = '0;
      hs = ~hs_hi; vs = ~vs_hi;
      case (mode)
        0: begin
          de = (line < 8) && (x >= 4) && (x < 4 + len);
          hs = (x == 17 || x == 18) ? hs_hi : ~hs_hi;
          vs = (line == 9) ? vs_hi : ~vs_hi;
        end
        1: begin
          de = (c == 3) || (c == 4);
          r  = (c == 3) ? BPC'(1) : '0;
          b  = (c == 4) ? BPC'(1) : '0;
        end
        default: de = (c >= 4) && (c < 4 + 65536);
      endcase
      cycle(c == 0, de, hs, vs, r, '0, b, c == rst_at);
      if (rst_at >= 0 && c == rst_at + 1) rst_snap = obs_all;
    end
  endtask

  initial begin
    res_t s;
    repeat (3) cycle(0, 0, 0, 0, '0, '0, '0, 1);
    cycle(0, 0, 0, 0, '0, '0, '0, 0);
    cycle(0, 0, 0, 0, '0, '0, '0, 0);
    chk("reset_outs_lo", obs_all[63:0], 64'd0);
    chk("reset_outs_hi", 64'(obs_all[108:64]), 64'd0);

    run_frame(0, 200, -1, 1, 1, -1);                 // F1
    chk("idle_first_frame_no_strobe", sq.size(), 0);
    run_frame(0, 200, -1, 1, 1, -1);                 // F2
    run_frame(0, 200, -1, 1, 1, -1);                 // F3
    run_frame(0, 200, 3, 1, 1, -1);                  // F4: line 3 short
    run_frame(0, 200, -1, 1, 1, -1);                 // F5
    run_frame(0, 200, -1, 1, 1, -1);                 // F6
    run_frame(0, 200, -1, 0, 0, -1);                 // F7: active-low syncs
    run_frame(0, 200, -1, 0, 0, -1);                 // F8
    run_frame(0, 200, -1, 0, 0, 100);                // F9: reset mid-frame
    chk("strobes_before_reset", sq.size(), 8);
    chk("midreset_outs_lo", rst_snap[63:0], 64'd0);
    chk("midreset_outs_hi", 64'(rst_snap[108:64]), 64'd0);
    run_frame(0, 200, -1, 1, 1, -1);                 // F10: starts in IDLE
    chk("no_strobe_after_reset", sq.size(), 8);
    run_frame(1, 10, -1, 1, 1, -1);                  // F11: signature frame
    run_frame(0, 1, -1, 1, 1, -1);                   // F12: one-cycle frame
    run_frame(2, 65556, -1, 1, 1, -1);               // F13: saturating DE run
    run_frame(0, 2, -1, 1, 1, -1);                   // F14: closes F13
    repeat (3) cycle(0, 0, 0, 0, '0, '0, '0, 0);

    s = sget(0);
    chk("nom_hres", s.hres, 12);
    chk("nom_vres", s.vres, 8);
    chk("nom_htotal", s.htotal, 20);
    chk("nom_frame_cycles", s.fc, 200);
    chk("nom_sig", s.sig, 0);
    chk("nom_err", s.err, 0);
    chk("nom_pol", {s.hp, s.vp}, 2'b11);
    chk("nom_strobe1_locked", s.lk, 0);
    chk("nom_strobe1_cycle", s.cyc, fget(1) + 1);
    chk("nom_strobe2_locked", sget(1).lk, 0);
    chk("nom_strobe3_locked", sget(2).lk, 1);
    chk("nom_strobe3_cycle", sget(2).cyc, fget(3) + 1);

    s = sget(3);
    chk("short_err", s.err, 1);
    chk("short_locked", s.lk, 0);
    chk("short_hres", s.hres, 12);
    chk("recover1_locked", sget(4).lk, 0);
    chk("recover2_locked", sget(5).lk, 1);
    chk("recover2_err", sget(5).err, 0);

    s = sget(7);
    chk("lowpol_pol", {s.hp, s.vp}, 2'b00);
    chk("lowpol_locked", s.lk, 1);

    s = sget(8);
    chk("post_reset_cycle", s.cyc, fget(10) + 1);
    chk("post_reset_fc", s.fc, 200);
    chk("post_reset_locked", s.lk, 0);

    s = sget(9);
    chk("sig_value", s.sig, 32'h0000_0801);
    chk("sig_hres", s.hres, 2);
    chk("sig_vres", s.vres, 1);
    chk("sig_htotal_single_run", s.htotal, 0);
    chk("sig_fc", s.fc, 10);
    chk("sig_err", s.err, 0);

    s = sget(10);
    chk("b2b_fc", s.fc, 1);
    chk("b2b_err", s.err, 1);
    chk("b2b_consecutive", s.cyc, sget(9).cyc + 1);

    s = sget(11);
    chk("sat_hres", s.hres, 16'hFFFF);
    chk("sat_err", s.err, 1);
    chk("sat_vres", s.vres, 1);
    chk("sat_fc", s.fc, 65556);
    chk("total_strobes", sq.size(), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
